// File: rtl/exc_arbiter_pkg.sv
// Package: exc_arbiter_pkg
// Shared definitions for the MEM-stage exception arbiter: CP0 exception codes,
// bit positions inside the EX->MEM cause-flag vector, FSM state encoding,
// the MEM-stage context record and a small EPC helper.
package exc_arbiter_pkg;

   typedef enum logic [4:0] {
      EC_INT  = 5'h00,
      EC_ADEL = 5'h04,
      EC_ADES = 5'h05,
      EC_SYS  = 5'h08,
      EC_BP   = 5'h09,
      EC_RI   = 5'h0A,
      EC_OV   = 5'h0C,
      EC_NONE = 5'h10,
      EC_ERET = 5'h11
   } exc_code_t;

   // Cause-flag vector layout: {adel_if, ri, ov, sys, bp, eret, mem_err}
   localparam int unsigned EXC_FLAGS = 7;
   localparam int unsigned F_MEM_ERR = 0;
   localparam int unsigned F_ERET    = 1;
   localparam int unsigned F_BP      = 2;
   localparam int unsigned F_SYS     = 3;
   localparam int unsigned F_OV      = 4;
   localparam int unsigned F_RI      = 5;
   localparam int unsigned F_ADEL_IF = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [31:0]          pc;
      logic                 in_delay;
      logic [EXC_FLAGS-1:0] exc;
      logic                 mem_we;
      logic [31:0]          mem_addr;
   } mem_ctx_t;

   // Delay-slot instructions restart at the branch, one word earlier.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_delay);
      return in_delay ? pc - 32'd4 : pc;
   endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// Interface: exc_arbiter_if
// Bundles the EX->MEM instruction context, CP0 status/cause/interrupt inputs
// and the arbiter's CP0-facing outputs.
//  master : pipeline/CP0 side (drives ex_*, stall, status, cause, interrupts)
//  slave  : exc_arbiter side (drives int_o, exc_*, in_delay_o, mem_kill_o, flush_busy_o)
interface exc_arbiter_if;
   import exc_arbiter_pkg::*;

   logic                 stall_i;
   logic                 ex_valid_i;
   logic [31:0]          ex_pc_i;
   logic                 ex_in_delay_i;
   logic [EXC_FLAGS-1:0] ex_exc_i;
   logic                 ex_mem_we_i;
   logic [31:0]          ex_mem_addr_i;
   logic [31:0]          status_i;
   logic [31:0]          cause_i;
   logic                 int_time_i;
   logic [5:0]           int_hw_i;

   logic [5:0]           int_o;
   logic [4:0]           exc_code_o;
   logic [31:0]          exc_epc_o;
   logic [31:0]          exc_badvaddr_o;
   logic                 in_delay_o;
   logic                 mem_kill_o;
   logic                 flush_busy_o;

   modport master (
      output stall_i, ex_valid_i, ex_pc_i, ex_in_delay_i, ex_exc_i,
             ex_mem_we_i, ex_mem_addr_i, status_i, cause_i, int_time_i, int_hw_i,
      input  int_o, exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o,
             mem_kill_o, flush_busy_o
   );

   modport slave (
      input  stall_i, ex_valid_i, ex_pc_i, ex_in_delay_i, ex_exc_i,
             ex_mem_we_i, ex_mem_addr_i, status_i, cause_i, int_time_i, int_hw_i,
      output int_o, exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o,
             mem_kill_o, flush_busy_o
   );

endinterface

// File: rtl/exc_arbiter_int_sync.sv
// Module: exc_arbiter_int_sync
// Multi-flop synchroniser for asynchronous interrupt lines.
//  clk  in  clock
//  rst  in  asynchronous, active-low reset (clears the whole chain)
//  d    in  WIDTH raw asynchronous inputs
//  q    out WIDTH inputs delayed by STAGES clocks
module exc_arbiter_int_sync
   import exc_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Stage 0 occupies the low WIDTH bits; the oldest sample sits at the top.
   logic [STAGES*WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
      end
   end

   assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/exc_arbiter.sv
// Module: exc_arbiter
// MEM-stage exception/interrupt arbiter feeding CP0. Registers the EX->MEM
// context, synchronises hardware interrupts, picks the highest-priority cause
// and drives CP0's exc_* / int_i inputs, then drops in-flight MEM slots for
// FLUSH_CYCLES cycles while CP0 redirects the PC.
//  clk  in  clock
//  rst  in  asynchronous, active-low reset
//  bus  slave modport of exc_arbiter_if:
//       in : stall_i, ex_valid_i, ex_pc_i, ex_in_delay_i, ex_exc_i, ex_mem_we_i,
//            ex_mem_addr_i, status_i, cause_i, int_time_i, int_hw_i
//       out: int_o, exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o,
//            mem_kill_o, flush_busy_o
module exc_arbiter
   import exc_arbiter_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic          clk,
   input  logic          rst,
   exc_arbiter_if.slave  bus
);

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   mem_ctx_t   mem;
   state_t     state;
   logic [2:0] cnt;
   logic       flush_busy;
   logic [5:0] int_q;
   logic [7:0] ip;
   logic       int_take;
   exc_code_t  code;
   logic [31:0] badvaddr;

   exc_arbiter_int_sync #(
      .WIDTH  (6),
      .STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.int_hw_i),
      .q   (int_q)
   );

   // MEM register. While flushing, valid is cleared even under stall so no
   // stale instruction survives into the following IDLE period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else if (!bus.stall_i) begin
         mem.valid    <= bus.ex_valid_i && (state == IDLE);
         mem.pc       <= bus.ex_pc_i;
         mem.in_delay <= bus.ex_in_delay_i;
         mem.exc      <= bus.ex_exc_i;
         mem.mem_we   <= bus.ex_mem_we_i;
         mem.mem_addr <= bus.ex_mem_addr_i;
      end else if (state == FLUSH) begin
         mem.valid <= 1'b0;
      end
   end

   assign ip       = {int_q[5] | bus.int_time_i, int_q[4:0], bus.cause_i[9:8]};
   assign int_take = (|(ip & bus.status_i[15:8])) && bus.status_i[0] && !bus.status_i[1];

   always_comb begin
      code     = EC_NONE;
      badvaddr = '0;
      if (mem.valid && !bus.stall_i && (state == IDLE)) begin
         if (int_take) begin
            code = EC_INT;
         end else if (mem.exc[F_ADEL_IF]) begin
            code     = EC_ADEL;
            badvaddr = mem.pc;
         end else if (mem.exc[F_RI]) begin
            code = EC_RI;
         end else if (mem.exc[F_OV]) begin
            code = EC_OV;
         end else if (mem.exc[F_SYS]) begin
            code = EC_SYS;
         end else if (mem.exc[F_BP]) begin
            code = EC_BP;
         end else if (mem.exc[F_ERET]) begin
            code = EC_ERET;
         end else if (mem.exc[F_MEM_ERR]) begin
            code     = mem.mem_we ? EC_ADES : EC_ADEL;
            badvaddr = mem.mem_addr;
         end
      end
   end

   // FLUSH length counts down regardless of stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         flush_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (code != EC_NONE) begin
                  state      <= FLUSH;
                  cnt        <= CNT_LOAD;
                  flush_busy <= 1'b1;
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state      <= IDLE;
                  flush_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: begin
               state      <= IDLE;
               flush_busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.int_o          = int_q;
   assign bus.exc_code_o     = code;
   assign bus.exc_epc_o      = epc_of(mem.pc, mem.in_delay);
   assign bus.exc_badvaddr_o = badvaddr;
   assign bus.in_delay_o     = (code != EC_NONE) && mem.in_delay;
   assign bus.mem_kill_o     = mem.valid && ((|mem.exc) || int_take || (state == FLUSH));
   assign bus.flush_busy_o   = flush_busy;

endmodule

// File: tb/tb_exc_arbiter.sv
// Testbench: tb_exc_arbiter
// Directed scenarios followed by randomized traffic. Each cycle the stimulus
// process pushes the expected CP0-side outputs into a scoreboard queue; a
// monitor on the falling edge pops and compares against the DUT.
module tb_exc_arbiter;

   localparam int FLUSH_CYCLES = 2;
   localparam int SYNC_STAGES  = 2;

   typedef struct packed {
      logic        stall;
      logic        valid;
      logic [31:0] pc;
      logic        dly;
      logic [6:0]  exc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] status;
      logic [31:0] cause;
      logic        tim;
      logic [5:0]  hw;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        dly;
      logic [6:0]  exc;
      logic        we;
      logic [31:0] addr;
   } slot_t;

   typedef struct packed {
      logic [5:0]  int_o;
      logic [4:0]  code;
      logic [31:0] epc;
      logic [31:0] badv;
      logic        dly;
      logic        kill;
      logic        busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   exc_arbiter_if bus();

   exc_arbiter #(
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t       sb[$];
   int         vectors     = 0;
   int         miscompares = 0;

   // Reference model state
   stim_t      cur;
   slot_t      m;
   int         flush_left;
   logic [5:0] hist[$];
   logic       rst_v;

   function automatic stim_t idle_stim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t instr(input logic [31:0] pc, input logic [6:0] exc, input logic dly);
      stim_t s;
      s       = idle_stim();
      s.valid = 1'b1;
      s.pc    = pc;
      s.exc   = exc;
      s.dly   = dly;
      return s;
   endfunction

   function automatic void model_reset();
      m          = '0;
      flush_left = 0;
      hist       = {};
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(6'h0);
   endfunction

   // Expected outputs for the current cycle from the model and current inputs.
   function automatic exp_t predict();
      exp_t        e;
      logic [7:0]  ip;
      logic        take;
      logic        flushing;
      logic        found;
      int          order_bit [6];
      logic [4:0]  order_code [6];
      order_bit  = '{6, 5, 4, 3, 2, 1};
      order_code = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h11};
      e        = '0;
      e.int_o  = hist[0];
      ip       = {hist[0][5] | cur.tim, hist[0][4:0], cur.cause[9:8]};
      take     = ((ip & cur.status[15:8]) != 8'h0) && cur.status[0] && !cur.status[1];
      flushing = flush_left > 0;
      e.code   = 5'h10;
      e.badv   = 32'h0;
      if (m.valid && !cur.stall && !flushing) begin
         if (take) begin
            e.code = 5'h00;
         end else begin
            found = 1'b0;
            for (int k = 0; k < 6; k++) begin
               if (!found && m.exc[order_bit[k]]) begin
                  found  = 1'b1;
                  e.code = order_code[k];
                  if (k == 0) e.badv = m.pc;
               end
            end
            if (!found && m.exc[0]) begin
               e.code = m.we ? 5'h05 : 5'h04;
               e.badv = m.addr;
            end
         end
      end
      e.epc  = m.dly ? m.pc - 32'd4 : m.pc;
      e.dly  = (e.code != 5'h10) ? m.dly : 1'b0;
      e.kill = m.valid && ((m.exc != 7'h0) || take || flushing);
      e.busy = flushing;
      return e;
   endfunction

   // Advance the model across one rising edge using the inputs held over it.
   function automatic void model_edge();
      exp_t e;
      if (!rst_v) return;
      e = predict();
      hist.push_back(cur.hw);
      void'(hist.pop_front());
      if (flush_left > 0) begin
         flush_left = flush_left - 1;
         if (!cur.stall) m = {1'b0, cur.pc, cur.dly, cur.exc, cur.we, cur.addr};
         else            m.valid = 1'b0;
      end else begin
         if (e.code != 5'h10) flush_left = FLUSH_CYCLES;
         if (!cur.stall) m = {cur.valid, cur.pc, cur.dly, cur.exc, cur.we, cur.addr};
      end
   endfunction

   task automatic drive(input stim_t s);
      cur               = s;
      bus.stall_i       = s.stall;
      bus.ex_valid_i    = s.valid;
      bus.ex_pc_i       = s.pc;
      bus.ex_in_delay_i = s.dly;
      bus.ex_exc_i      = s.exc;
      bus.ex_mem_we_i   = s.we;
      bus.ex_mem_addr_i = s.addr;
      bus.status_i      = s.status;
      bus.cause_i       = s.cause;
      bus.int_time_i    = s.tim;
      bus.int_hw_i      = s.hw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic apply(input logic r, input stim_t s);
      rst   = r;
      rst_v = r;
      if (!r) model_reset();
      drive(s);
      sb.push_back(predict());
   endtask

   task automatic step(input logic r, input stim_t s);
      tick();
      apply(r, s);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         cmp("int_o",          32'(bus.int_o),          32'(e.int_o));
         cmp("exc_code_o",     32'(bus.exc_code_o),     32'(e.code));
         cmp("exc_epc_o",      bus.exc_epc_o,           e.epc);
         cmp("exc_badvaddr_o", bus.exc_badvaddr_o,      e.badv);
         cmp("in_delay_o",     32'(bus.in_delay_o),     32'(e.dly));
         cmp("mem_kill_o",     32'(bus.mem_kill_o),     32'(e.kill));
         cmp("flush_busy_o",   32'(bus.flush_busy_o),   32'(e.busy));
      end
   end

   initial begin
      stim_t      s;
      logic [5:0] hw_r;
      rst   = 1'b0;
      rst_v = 1'b0;
      model_reset();
      drive(idle_stim());

      // Reset values
      step(1'b0, idle_stim());
      step(1'b0, idle_stim());
      step(1'b1, idle_stim());

      // ov+sys in a delay slot: Ov wins, EPC backs up one word
      step(1'b1, instr(32'h8000_1000, 7'b0011000, 1'b1));
      repeat (4) step(1'b1, idle_stim());

      // Store address error
      s = instr(32'h0000_2000, 7'b0000001, 1'b0);
      s.we = 1'b1; s.addr = 32'h0000_0003;
      step(1'b1, s);
      repeat (4) step(1'b1, idle_stim());

      // Delay slot at pc=0 wraps the EPC
      step(1'b1, instr(32'h0000_0000, 7'b0000100, 1'b1));
      repeat (4) step(1'b1, idle_stim());

      // Hardware interrupt 2 with IM4+IE, plus a fault on the same instruction
      s = idle_stim(); s.hw = 6'b000100; s.status = 32'h0000_1001;
      repeat (3) step(1'b1, s);
      s.valid = 1'b1; s.pc = 32'h0000_0100; s.exc = 7'b0100000;
      step(1'b1, s);
      s.valid = 1'b0; s.exc = 7'h0;
      repeat (4) step(1'b1, s);

      // Same interrupt masked by EXL, then taken once EXL clears
      s.status = 32'h0000_1003; s.valid = 1'b1; s.pc = 32'h0000_0200;
      repeat (3) step(1'b1, s);
      s.status = 32'h0000_1001; s.pc = 32'h0000_0204;
      step(1'b1, s);
      s = idle_stim();
      repeat (5) step(1'b1, s);

      // Eret held by a 3-cycle stall
      step(1'b1, instr(32'h0000_0300, 7'b0000010, 1'b0));
      s = idle_stim(); s.stall = 1'b1;
      repeat (3) step(1'b1, s);
      repeat (4) step(1'b1, idle_stim());

      // Reset while FLUSH counter is at 1
      step(1'b1, instr(32'h0000_0400, 7'b0000100, 1'b0));
      step(1'b1, idle_stim());
      step(1'b0, idle_stim());
      step(1'b1, idle_stim());
      repeat (2) step(1'b1, idle_stim());

      // Randomized traffic
      hw_r = 6'h0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         s        = idle_stim();
         s.stall  = (flush_left == 0) && ($urandom_range(0, 4) == 0);
         s.valid  = ($urandom_range(0, 9) < 7);
         s.pc     = 32'($urandom) & 32'hFFFF_FFFC;
         s.dly    = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < 7; b++) s.exc[b] = ($urandom_range(0, 9) == 0);
         s.we     = 1'($urandom);
         s.addr   = 32'($urandom);
         s.status = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0)};
         s.cause  = 32'($urandom) & (($urandom_range(0, 7) == 0) ? 32'h0000_0300 : 32'h0);
         s.tim    = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) hw_r = 6'($urandom) & 6'($urandom) & 6'($urandom);
         s.hw     = hw_r;
         apply(1'b1, s);
      end

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
